// File: rtl/dino_pkg.sv
// Shared encodings for the dino game: per-player state codes and global game states.
package dino_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIVES_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PS_IDLE    = 3'b000,
        PS_JUMPING = 3'b001,
        PS_RUN1    = 3'b010,
        PS_RUN2    = 3'b011,
        PS_DUCKING = 3'b100,
        PS_DEAD    = 3'b101,
        PS_RESPAWN = 3'b110
    } player_state_e;

    typedef enum logic [1:0] {
        GS_RESTART   = 2'd0,
        GS_PLAY      = 2'd1,
        GS_PAUSED    = 2'd2,
        GS_GAME_OVER = 2'd3
    } game_state_e;

endpackage

// File: rtl/player_lane.sv
// One player's lane: run/jump/duck FSM, lives, respawn invulnerability and jump physics.
module player_lane
    import dino_pkg::*;
#(
    parameter int unsigned POS_W        = 6,
    parameter int unsigned JUMP_H       = 20,
    parameter int unsigned MAX_JUMPS    = 2,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned INVULN_TICKS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                play,
    input  logic                start,
    input  logic                tick0,
    input  logic                tick1,
    input  logic                up,
    input  logic                up_rise,
    input  logic                down,
    input  logic                crash,
    output player_state_e       state,
    output logic [POS_W-1:0]    position,
    output logic [LIVES_W-1:0]  lives,
    output logic                jump_pulse,
    output logic                dead_c
);

    localparam int unsigned JUMP_W = $clog2(MAX_JUMPS + 1);
    localparam int unsigned RISE_W = $clog2(JUMP_H + 1);
    localparam int unsigned INV_W  = (INVULN_TICKS == 0) ? 1 : $clog2(INVULN_TICKS + 1);
    localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};

    player_state_e       state_nxt;
    logic [POS_W-1:0]    position_nxt;
    logic [LIVES_W-1:0]  lives_nxt;
    logic                jump_pulse_nxt;
    logic [JUMP_W-1:0]   jumps_used, jumps_used_nxt;
    logic [RISE_W-1:0]   rise_cnt, rise_cnt_nxt;
    logic [INV_W-1:0]    invuln_cnt, invuln_cnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PS_IDLE;
            position   <= '0;
            lives      <= LIVES_W'(LIVES);
            jump_pulse <= 1'b0;
            jumps_used <= '0;
            rise_cnt   <= '0;
            invuln_cnt <= '0;
        end else begin
            state      <= state_nxt;
            position   <= position_nxt;
            lives      <= lives_nxt;
            jump_pulse <= jump_pulse_nxt;
            jumps_used <= jumps_used_nxt;
            rise_cnt   <= rise_cnt_nxt;
            invuln_cnt <= invuln_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        position_nxt   = position;
        lives_nxt      = lives;
        jump_pulse_nxt = 1'b0;
        jumps_used_nxt = jumps_used;
        rise_cnt_nxt   = rise_cnt;
        invuln_cnt_nxt = invuln_cnt;

        if (start) begin
            state_nxt      = PS_RUN1;
            position_nxt   = '0;
            lives_nxt      = LIVES_W'(LIVES);
            jumps_used_nxt = '0;
            rise_cnt_nxt   = '0;
            invuln_cnt_nxt = '0;
        end else if (!(state inside {PS_IDLE, PS_JUMPING, PS_RUN1, PS_RUN2,
                                     PS_DUCKING, PS_DEAD, PS_RESPAWN})) begin
            state_nxt = PS_IDLE;
        end else if (play) begin
            // A crash pre-empts any tick action of this lane in the same cycle.
            if (crash && (state inside {PS_RUN1, PS_RUN2, PS_JUMPING, PS_DUCKING})) begin
                lives_nxt      = lives - LIVES_W'(1);
                position_nxt   = '0;
                jumps_used_nxt = '0;
                rise_cnt_nxt   = '0;
                if (lives <= LIVES_W'(1)) begin
                    state_nxt      = PS_DEAD;
                    invuln_cnt_nxt = '0;
                end else begin
                    state_nxt      = PS_RESPAWN;
                    invuln_cnt_nxt = INV_W'(INVULN_TICKS);
                end
            end else begin
                case (state)
                    PS_RUN1, PS_RUN2: begin
                        if (tick0) begin
                            if (down) begin
                                state_nxt = PS_DUCKING;
                            end else if (up) begin
                                state_nxt      = PS_JUMPING;
                                jump_pulse_nxt = 1'b1;
                                jumps_used_nxt = JUMP_W'(1);
                                rise_cnt_nxt   = RISE_W'(JUMP_H);
                            end else begin
                                state_nxt = (state == PS_RUN1) ? PS_RUN2 : PS_RUN1;
                            end
                        end
                    end
                    PS_JUMPING: begin
                        if (tick0 && up_rise && (jumps_used < JUMP_W'(MAX_JUMPS))) begin
                            jump_pulse_nxt = 1'b1;
                            jumps_used_nxt = jumps_used + JUMP_W'(1);
                            rise_cnt_nxt   = RISE_W'(JUMP_H);
                        end else if (tick1) begin
                            if (rise_cnt != '0) begin
                                rise_cnt_nxt = rise_cnt - RISE_W'(1);
                                if (position != POS_MAX) begin
                                    position_nxt = position + POS_W'(1);
                                end
                            end else if (position <= POS_W'(1)) begin
                                position_nxt   = '0;
                                state_nxt      = PS_RUN1;
                                jumps_used_nxt = '0;
                            end else begin
                                position_nxt = position - POS_W'(1);
                            end
                        end
                    end
                    PS_DUCKING: begin
                        position_nxt = '0;
                        if (tick0 && !down) begin
                            state_nxt = PS_RUN1;
                        end
                    end
                    PS_RESPAWN: begin
                        if (tick0) begin
                            if (invuln_cnt <= INV_W'(1)) begin
                                invuln_cnt_nxt = '0;
                                state_nxt      = PS_RUN1;
                            end else begin
                                invuln_cnt_nxt = invuln_cnt - INV_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dead_c = (state == PS_DEAD);

endmodule

// File: rtl/player_array_ctrl.sv
// Multi-player dino controller: global game FSM, shared button edge detection, one lane per player.
module player_array_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned N_PLAYERS    = 2,
    parameter int unsigned POS_W        = 6,
    parameter int unsigned JUMP_H       = 20,
    parameter int unsigned MAX_JUMPS    = 2,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned INVULN_TICKS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    game_tick,
    input  logic                          button_start,
    input  logic                          button_pause,
    input  logic [N_PLAYERS-1:0]          button_up,
    input  logic [N_PLAYERS-1:0]          button_down,
    input  logic [N_PLAYERS-1:0]          crash,
    output logic [N_PLAYERS*POS_W-1:0]    player_position,
    output logic [N_PLAYERS*STATE_W-1:0]  player_state,
    output logic [N_PLAYERS*LIVES_W-1:0]  lives_left,
    output logic [N_PLAYERS-1:0]          jump_pulse,
    output logic [1:0]                    game_state,
    output logic                          game_frozen,
    output logic                          game_start_pulse,
    output logic                          game_over_pulse
);

    game_state_e            gs, gs_nxt;
    logic                   pause_prev;
    logic [N_PLAYERS-1:0]   up_prev;
    logic [N_PLAYERS-1:0]   up_rise;
    logic [N_PLAYERS-1:0]   dead;
    logic                   tick0, tick1, pause_rise, all_dead, play;

    assign tick0      = game_tick[0];
    assign tick1      = game_tick[1];
    assign pause_rise = tick0 && button_pause && !pause_prev;
    assign up_rise    = {N_PLAYERS{tick0}} & button_up & ~up_prev;
    assign all_dead   = &dead;
    assign play       = (gs == GS_PLAY);
    assign game_state = gs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gs          <= GS_RESTART;
            pause_prev  <= 1'b0;
            up_prev     <= '0;
            game_frozen <= 1'b1;
        end else begin
            gs          <= gs_nxt;
            game_frozen <= (gs_nxt != GS_PLAY);
            if (tick0) begin
                pause_prev <= button_pause;
                up_prev    <= button_up;
            end
        end
    end

    // Start outranks pause in RESTART/GAME_OVER simply because those states ignore pause.
    always_comb begin
        gs_nxt           = gs;
        game_start_pulse = 1'b0;
        game_over_pulse  = 1'b0;
        case (gs)
            GS_RESTART, GS_GAME_OVER: begin
                if (tick0 && button_start) begin
                    gs_nxt           = GS_PLAY;
                    game_start_pulse = 1'b1;
                end
            end
            GS_PLAY: begin
                if (all_dead) begin
                    gs_nxt          = GS_GAME_OVER;
                    game_over_pulse = 1'b1;
                end else if (pause_rise) begin
                    gs_nxt = GS_PAUSED;
                end
            end
            GS_PAUSED: begin
                if (pause_rise) begin
                    gs_nxt = GS_PLAY;
                end
            end
            default: gs_nxt = GS_RESTART;
        endcase
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_lane
        player_state_e lane_state;

        player_lane #(
            .POS_W        (POS_W),
            .JUMP_H       (JUMP_H),
            .MAX_JUMPS    (MAX_JUMPS),
            .LIVES        (LIVES),
            .INVULN_TICKS (INVULN_TICKS)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .play       (play),
            .start      (game_start_pulse),
            .tick0      (tick0),
            .tick1      (tick1),
            .up         (button_up[i]),
            .up_rise    (up_rise[i]),
            .down       (button_down[i]),
            .crash      (crash[i]),
            .state      (lane_state),
            .position   (player_position[i*POS_W +: POS_W]),
            .lives      (lives_left[i*LIVES_W +: LIVES_W]),
            .jump_pulse (jump_pulse[i]),
            .dead_c     (dead[i])
        );

        assign player_state[i*STATE_W +: STATE_W] = lane_state;
    end

endmodule

// File: doc/player_array_ctrl.md
PLAYER_ARRAY_CTRL -- requirements
Module: player_array_ctrl

Interface
REQ-001 Parameter N_PLAYERS, default 2, number of independent players (1..4).
REQ-002 Parameter POS_W, default 6, player height width in bits.
REQ-003 Parameter JUMP_H, default 20, rise ticks per jump (1..2^POS_W-1).
REQ-004 Parameter MAX_JUMPS, default 2, jumps allowed per airtime (1 = no double jump).
REQ-005 Parameter LIVES, default 3, lives per player per game (1..7).
REQ-006 Parameter INVULN_TICKS, default 16, game_tick[0] periods of respawn invulnerability.
REQ-007 clk  in  1  system clock.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 game_tick  in  2  single-cycle strobes: [0] input-sample tick, [1] physics tick.
REQ-010 button_start, button_pause  in  1 each  shared buttons, level.
REQ-011 button_up, button_down, crash  in  N_PLAYERS each  per-player levels.
REQ-012 player_position  out  N_PLAYERS*POS_W  heights, player i at [i*POS_W +: POS_W].
REQ-013 player_state  out  N_PLAYERS*3  per-player state codes.
REQ-014 lives_left  out  N_PLAYERS*3  remaining lives.
REQ-015 jump_pulse  out  N_PLAYERS  one-cycle jump strobes.
REQ-016 game_state  out  2  RESTART=0, PLAY=1, PAUSED=2, GAME_OVER=3.
REQ-017 game_frozen, game_start_pulse, game_over_pulse  out  1 each.

Function
REQ-018 Player codes: RUN1=010, RUN2=011, JUMPING=001, DUCKING=100, DEAD=101, RESPAWN=110, IDLE=000; unused codes SHALL go to IDLE.
REQ-019 Global RESTART/GAME_OVER: tick0 & button_start -> PLAY next cycle; all players RUN1, lives=LIVES, positions 0; game_start_pulse high that cycle (combinational).
REQ-020 PLAY: tick0 & button_pause rising edge (vs. previous tick0 sample) -> PAUSED; PAUSED: same condition -> PLAY.
REQ-021 PAUSED: all player state, counters, positions frozen; crash ignored.
REQ-022 game_frozen SHALL be 1 whenever game_state != PLAY.
REQ-023 Player updates occur only in PLAY; crash has priority over every tick action for the same player in the same cycle.
REQ-024 Crash in RUN1/RUN2/JUMPING/DUCKING: lives decrement; result 0 -> DEAD, else RESPAWN with invuln counter=INVULN_TICKS, position cleared.
REQ-025 RESPAWN: crash ignored; counter decrements per tick0; at 0 -> RUN1.
REQ-026 RUN1/RUN2 on tick0: down -> DUCKING; else up -> JUMPING with jump_pulse; else toggle RUN1/RUN2.
REQ-027 JUMPING on tick0: up rising edge with jumps_used < MAX_JUMPS -> jump_pulse, jumps_used+1, rise restarts from current height.
REQ-028 JUMPING on tick1 with jump_done -> RUN1, jumps_used=0.
REQ-029 DUCKING on tick0 & !down -> RUN1; position held 0.
REQ-030 Physics per tick1: rise +1 for JUMP_H ticks, saturating at 2^POS_W-1, then fall -1; jump_done when fall reaches 0.
REQ-031 Transition to GAME_OVER when all players DEAD; game_over_pulse high exactly one cycle, that transition cycle.
REQ-032 Start in GAME_OVER on the same tick0 as pause: start wins, pause ignored.

Reset
REQ-033 rst_n low at a clock edge: game_state=RESTART, players IDLE, positions 0, lives=LIVES, counters 0, edge registers 0, pulses 0.
REQ-034 Reset mid-jump or mid-pause SHALL fully override in-flight state in one cycle.

Structure
REQ-035 State codes and game_state encodings SHALL live in shared package dino_pkg.
REQ-036 One sub-module player_lane (per-player FSM, lives, invuln, physics) instantiated N_PLAYERS times via generate; top holds global FSM and edge detection.

Verification
REQ-037 Reset, start on tick0 -> game_state=1, all RUN1, lives=3, game_start_pulse one cycle.
REQ-038 P0 up on tick0, held; second up edge at height 10 -> two jump_pulses, peak 30, third edge ignored, lands -> RUN1.
REQ-039 P1 crash x3 (after invuln expiry) -> lives 2,1,0, RESPAWN twice then DEAD; crash during RESPAWN leaves lives unchanged.
REQ-040 Pause mid-jump at height 7 for 50 ticks -> position stays 7, crash ignored; unpause resumes rise.
REQ-041 All players DEAD -> GAME_OVER, game_over_pulse one cycle; start+pause same tick0 -> PLAY, lives reloaded.
REQ-042 rst_n low mid-jump -> next cycle all outputs at reset values.
